exception_ctrl: RTL
===================

// Module: exception_ctrl
// PURPOSE
//  Commit-side exception/interrupt controller: the initiator that drives the CSR block's ctrl_csr port.
//  Takes the committing instruction's exception flags, ertn and idle, plus the CSR interrupt state.
//  Produces the CSR exception commit (cause, ecode/esubcode, pc, addr), a pipeline flush pulse and a redirect PC.
//  Runs a RUN/DRAIN/IDLE state machine.
// PARAMETERS
//  FLUSH_CYCLES  2  cycles in DRAIN after a flush, during which commits are ignored (>=1)
//  CAUSE_W       7  width of exception_cause; values are the `EXCEPTION_* codes in csr_defines.sv
// PORTS
//  clk                  in   1   clock
//  rst_n                in   1   asynchronous active-low reset
//  commit_valid         in   1   one instruction commits this cycle
//  commit_pc            in   32  PC of the committing instruction
//  commit_addr          in   32  memory VA of the committing load/store
//  commit_exc           in   15  flags {adef,tlbr_f,pif,ppi_f,ine,ipe,sys,brk,ale,adem,tlbr_m,pil,pis,pme,ppi_m}, bit14 = adef
//  commit_ertn          in   1   committing instruction is ertn
//  commit_idle          in   1   committing instruction is idle
//  crmd_ie              in   1   CRMD.IE
//  ecfg_lie             in   12  ECFG.LIE {12:11,9:0}
//  estat_is             in   12  ESTAT.IS {12:11,9:0}
//  eentry_va            in   32  EENTRY, low 6 bits are zero
//  tlbrentry_va         in   32  TLBRENTRY
//  era_pc               in   32  ERA
//  is_exception         out  1   one-cycle pulse: the CSR commits an exception
//  exception_cause      out  CAUSE_W  `EXCEPTION_* code
//  ecode                out  6   ESTAT.Ecode
//  esubcode             out  9   ESTAT.EsubCode
//  exception_pc         out  32  PC written to ERA
//  exception_addr       out  32  BADV source
//  is_syscall_break     out  1   high with is_exception when the cause is SYS or BRK
//  is_ertn              out  1   one-cycle pulse: ertn commit
//  flush                out  1   one-cycle pulse: squash all younger instructions
//  redirect_valid       out  1   equal to flush
//  redirect_pc          out  32  new fetch PC
//  fetch_stall          out  1   high throughout IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, state=RUN, int_q=0. Reset mid-DRAIN or mid-IDLE returns to RUN immediately.
//  - int_q is a register that samples |(ecfg_lie & estat_is) every cycle.
//  - int_take = int_q & crmd_ie.
//  - All outputs are registered. A decision made on the commit in cycle N appears in cycle N+1 for exactly 1 cycle.
//  - RUN, commit_valid=1, priority high to low:
//    - INT (int_take): ecode 0x0, esub 0.
//    - ADEF: 0x8, esub 0.
//    - TLBR fetch: 0x3F.
//    - PIF: 0x3.
//    - PPI fetch: 0x7.
//    - INE: 0xD.
//    - IPE: 0xE.
//    - SYS: 0xB.
//    - BRK: 0xC.
//    - ALE: 0x9.
//    - ADEM: 0x8, esub 1.
//    - TLBR mem: 0x3F.
//    - PIL: 0x1.
//    - PIS: 0x2.
//    - PME: 0x4.
//    - PPI mem: 0x7.
//  - Fields driven on exception:
//    - exception_pc = commit_pc; for INT on an idle commit it is commit_pc+4.
//    - exception_addr = commit_addr for memory causes; commit_pc for ADEF and fetch-side causes.
//    - redirect_pc = tlbrentry_va for either TLBR, else eentry_va. Both are sampled in cycle N.
//  - Any exception: is_exception=flush=redirect_valid=1, then DRAIN.
//  - Exception and commit_ertn together: the exception wins and is_ertn stays 0.
//  - ertn with no exception: is_ertn=flush=1, redirect_pc=era_pc sampled in cycle N, then DRAIN.
//  - idle with no exception and int_q=0: flush=1, redirect_pc=commit_pc+4, fetch_stall=1 from N+1, then IDLE.
//    - The idle PC+4 is latched internally.
//  - idle while int_take=1: INT exception with exception_pc=idle PC+4. IDLE is not entered.
//  - DRAIN: a counter loads FLUSH_CYCLES and decrements to 0, then the FSM returns to RUN.
//    - commit_valid is ignored in DRAIN, including interrupts.
//  - IDLE: stays until int_q=1. On wake:
//    - int_take=1: INT exception, exception_pc=latched PC+4, redirect to eentry_va, then DRAIN.
//    - crmd_ie=0: no exception; flush=1 with redirect_pc=latched PC+4, then DRAIN.
//    - In both cases fetch_stall drops on the cycle flush asserts.
//  - commit_valid=0 in RUN: no outputs asserted. A pending interrupt waits for the next commit.
//  - Arithmetic: PC+4 is 32-bit wrap-around (0xFFFFFFFC -> 0x00000000).
// TESTING
//  - SYS at pc 0x1C000100, eentry 0x1C008000 -> N+1: is_exception=1, ecode=0xB, is_syscall_break=1, redirect 0x1C008000; DRAIN 2 cycles drops commits.
//  - ADEF+INE+ALE together, pc 0x3 -> ecode 0x8, esub 0, exception_addr=0x3.
//  - TLBR mem, addr 0x00400010, tlbrentry 0x1C00F000 -> ecode 0x3F, badv 0x00400010, redirect 0x1C00F000.
//  - lie=is=0x800, ie=1, commit pc 0x1C000200 -> INT ecode 0, exception_pc 0x1C000200. With ie=0 -> no exception.
//  - idle at 0x1C000300 -> fetch_stall; is=0x004 after 10 cycles:
//    - ie=1: INT, exception_pc 0x1C000304.
//    - ie=0: flush, redirect 0x1C000304.
//  - ertn, era 0x1C000404 -> is_ertn, redirect 0x1C000404. ertn+IPE -> IPE only. rst_n low in DRAIN -> outputs 0 and RUN.

Source files
------------

// File: rtl/exception_ctrl.sv
// Commit-side exception/interrupt controller: prioritises commit exceptions,
// interrupts, ertn and idle into registered CSR-commit, flush and redirect pulses.
module exception_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CAUSE_W      = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic [31:0]        commit_addr,
  input  logic [14:0]        commit_exc,
  input  logic               commit_ertn,
  input  logic               commit_idle,
  input  logic               crmd_ie,
  input  logic [11:0]        ecfg_lie,
  input  logic [11:0]        estat_is,
  input  logic [31:0]        eentry_va,
  input  logic [31:0]        tlbrentry_va,
  input  logic [31:0]        era_pc,
  output logic               is_exception,
  output logic [CAUSE_W-1:0] exception_cause,
  output logic [5:0]         ecode,
  output logic [8:0]         esubcode,
  output logic [31:0]        exception_pc,
  output logic [31:0]        exception_addr,
  output logic               is_syscall_break,
  output logic               is_ertn,
  output logic               flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               fetch_stall
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  // Cause codes: 1 = INT, 2..16 follow the flag priority order ADEF .. PPI_M.
  localparam logic [CAUSE_W-1:0] CAUSE_INT = CAUSE_W'(1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_IDLE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               int_q, int_d;
  logic [31:0]        idle_pc_q, idle_pc_d;

  logic               is_exception_q, is_exception_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [5:0]         ecode_q, ecode_d;
  logic [8:0]         esub_q, esub_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        eaddr_q, eaddr_d;
  logic               sysbrk_q, sysbrk_d;
  logic               ertn_q, ertn_d;
  logic               flush_q, flush_d;
  logic [31:0]        rpc_q, rpc_d;
  logic               stall_q, stall_d;

  logic               int_take;
  logic [31:0]        pc_plus4;
  logic               exc_hit;
  logic [3:0]         exc_sel;
  logic [14:0]        exc_code;

  function automatic logic [14:0] code_of(input logic [3:0] b);
    logic [14:0] r; // {esubcode, ecode}
    case (b)
      4'd14:   r = {9'd0, 6'h08};
      4'd13:   r = {9'd0, 6'h3F};
      4'd12:   r = {9'd0, 6'h03};
      4'd11:   r = {9'd0, 6'h07};
      4'd10:   r = {9'd0, 6'h0D};
      4'd9:    r = {9'd0, 6'h0E};
      4'd8:    r = {9'd0, 6'h0B};
      4'd7:    r = {9'd0, 6'h0C};
      4'd6:    r = {9'd0, 6'h09};
      4'd5:    r = {9'd1, 6'h08};
      4'd4:    r = {9'd0, 6'h3F};
      4'd3:    r = {9'd0, 6'h01};
      4'd2:    r = {9'd0, 6'h02};
      4'd1:    r = {9'd0, 6'h04};
      4'd0:    r = {9'd0, 6'h07};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign int_d    = |(ecfg_lie & estat_is);
  assign int_take = int_q & crmd_ie;
  assign pc_plus4 = commit_pc + 32'd4;

  // Higher bit index has higher priority, so the last set bit scanned wins.
  always_comb begin
    exc_hit = 1'b0;
    exc_sel = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (commit_exc[i]) begin
        exc_hit = 1'b1;
        exc_sel = 4'(i);
      end
    end
  end

  assign exc_code = code_of(exc_sel);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idle_pc_d      = idle_pc_q;
    is_exception_d = 1'b0;
    cause_d        = '0;
    ecode_d        = '0;
    esub_d         = '0;
    epc_d          = '0;
    eaddr_d        = '0;
    sysbrk_d       = 1'b0;
    ertn_d         = 1'b0;
    flush_d        = 1'b0;
    rpc_d          = '0;

    case (state_q)
      S_RUN: begin
        if (commit_valid) begin
          if (int_take) begin
            is_exception_d = 1'b1;
            flush_d        = 1'b1;
            cause_d        = CAUSE_INT;
            epc_d          = commit_idle ? pc_plus4 : commit_pc;
            eaddr_d        = commit_pc;
            rpc_d          = eentry_va;
            state_d        = S_DRAIN;
            cnt_d          = CNT_W'(FLUSH_CYCLES);
          end else if (exc_hit) begin
            is_exception_d = 1'b1;
            flush_d        = 1'b1;
            cause_d        = CAUSE_W'(16 - 32'(exc_sel));
            ecode_d        = exc_code[5:0];
            esub_d         = exc_code[14:6];
            epc_d          = commit_pc;
            eaddr_d        = (exc_sel <= 4'd6) ? commit_addr : commit_pc;
            sysbrk_d       = (exc_sel == 4'd8) || (exc_sel == 4'd7);
            rpc_d          = ((exc_sel == 4'd13) || (exc_sel == 4'd4)) ? tlbrentry_va : eentry_va;
            state_d        = S_DRAIN;
            cnt_d          = CNT_W'(FLUSH_CYCLES);
          end else if (commit_ertn) begin
            ertn_d  = 1'b1;
            flush_d = 1'b1;
            rpc_d   = era_pc;
            state_d = S_DRAIN;
            cnt_d   = CNT_W'(FLUSH_CYCLES);
          end else if (commit_idle) begin
            flush_d = 1'b1;
            rpc_d   = pc_plus4;
            // A masked-but-pending interrupt would wake IDLE at once; skip it.
            if (int_q) begin
              state_d = S_DRAIN;
              cnt_d   = CNT_W'(FLUSH_CYCLES);
            end else begin
              idle_pc_d = pc_plus4;
              state_d   = S_IDLE;
            end
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (int_q) begin
          flush_d = 1'b1;
          rpc_d   = idle_pc_q;
          if (crmd_ie) begin
            is_exception_d = 1'b1;
            cause_d        = CAUSE_INT;
            epc_d          = idle_pc_q;
            eaddr_d        = idle_pc_q;
            rpc_d          = eentry_va;
          end
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign stall_d = (state_d == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      cnt_q          <= '0;
      int_q          <= 1'b0;
      idle_pc_q      <= '0;
      is_exception_q <= 1'b0;
      cause_q        <= '0;
      ecode_q        <= '0;
      esub_q         <= '0;
      epc_q          <= '0;
      eaddr_q        <= '0;
      sysbrk_q       <= 1'b0;
      ertn_q         <= 1'b0;
      flush_q        <= 1'b0;
      rpc_q          <= '0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      int_q          <= int_d;
      idle_pc_q      <= idle_pc_d;
      is_exception_q <= is_exception_d;
      cause_q        <= cause_d;
      ecode_q        <= ecode_d;
      esub_q         <= esub_d;
      epc_q          <= epc_d;
      eaddr_q        <= eaddr_d;
      sysbrk_q       <= sysbrk_d;
      ertn_q         <= ertn_d;
      flush_q        <= flush_d;
      rpc_q          <= rpc_d;
      stall_q        <= stall_d;
    end
  end

  assign is_exception     = is_exception_q;
  assign exception_cause  = cause_q;
  assign ecode            = ecode_q;
  assign esubcode         = esub_q;
  assign exception_pc     = epc_q;
  assign exception_addr   = eaddr_q;
  assign is_syscall_break = sysbrk_q;
  assign is_ertn          = ertn_q;
  assign flush            = flush_q;
  assign redirect_valid   = flush_q;
  assign redirect_pc      = rpc_q;
  assign fetch_stall      = stall_q;

endmodule
